// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc_if
// Brief    : Request/response bundle of the multi-cycle ALU
//            (start, operands, opcode in; result, flags, handshake out).
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b, ALUControl,
        input  result, zero, busy, done
    );

    modport slave (
        input  start, a, b, ALUControl,
        output result, zero, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Brief    : Multi-cycle ALU - single-cycle logic/arith ops plus iterative
//            shift-add multiply and restoring divide/remainder.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 64
) (
    input  logic     clk,
    input  logic     reset,
    alu_mc_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0]    c_idle = 1'b0;
    localparam logic [0:0]    c_run  = 1'b1;
    localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
    localparam logic [1:0]    c_mul  = 2'b00;
    localparam logic [1:0]    c_div  = 2'b01;

    logic [0:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH:0]   r_acc;     // MUL accumulator (low bits) / partial remainder
    logic [WIDTH-1:0] r_x;       // multiplicand or divisor
    logic [WIDTH-1:0] r_y;       // multiplier or dividend/quotient shift register
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_done;

    logic             w_iter;
    logic [WIDTH-1:0] w_simple;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_rem_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_final;

    assign w_iter = (bus.ALUControl == 4'b1000) || (bus.ALUControl == 4'b1001) ||
                    (bus.ALUControl == 4'b1010);

    always_comb begin
        w_simple = '1;
        case (bus.ALUControl)
            4'b0000: w_simple = bus.a & bus.b;
            4'b0001: w_simple = bus.a | bus.b;
            4'b0010: w_simple = bus.a + bus.b;
            4'b0110: w_simple = bus.a - bus.b;
            4'b0111: w_simple = bus.b;
            default: w_simple = '1;
        endcase
    end

    assign w_mul_acc   = r_acc[WIDTH-1:0] + (r_y[0] ? r_x : '0);

    // No borrow on the trial subtraction means the quotient bit is 1.
    assign w_rem_shift = {r_acc[WIDTH-1:0], r_y[WIDTH-1]};
    assign w_trial     = w_rem_shift - {1'b0, r_x};
    assign w_qbit      = ~w_trial[WIDTH];
    assign w_rem_next  = w_qbit ? w_trial : w_rem_shift;
    assign w_quo_next  = {r_y[WIDTH-2:0], w_qbit};

    always_comb begin
        w_final = w_rem_next[WIDTH-1:0];
        if (r_op == c_mul)
            w_final = w_mul_acc;
        else if (r_op == c_div)
            w_final = w_quo_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_idle;
            r_cnt    <= '0;
            r_op     <= c_mul;
            r_acc    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.start) begin
                        if (w_iter) begin
                            r_state <= c_run;
                            r_cnt   <= '0;
                            r_op    <= bus.ALUControl[1:0];
                            r_acc   <= '0;
                            r_x     <= (bus.ALUControl[1:0] == c_mul) ? bus.a : bus.b;
                            r_y     <= (bus.ALUControl[1:0] == c_mul) ? bus.b : bus.a;
                        end else begin
                            r_result <= w_simple;
                            r_zero   <= (w_simple == '0);
                            r_done   <= 1'b1;
                        end
                    end
                end
                c_run: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == c_mul) begin
                        r_acc <= {1'b0, w_mul_acc};
                        r_x   <= r_x << 1;
                        r_y   <= r_y >> 1;
                    end else begin
                        r_acc <= w_rem_next;
                        r_y   <= w_quo_next;
                    end
                    if (r_cnt == c_last) begin
                        r_state  <= c_idle;
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.done   = r_done;
    assign bus.busy   = (r_state == c_run);
endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised successor to the single-cycle datapath ALU. It executes the existing logic/arithmetic/pass-B operations with one-cycle registered latency. It adds unsigned multiply, divide and remainder, computed iteratively over WIDTH cycles. A start/busy/done handshake lets the multi-cycle processor's control FSM stall while an iterative operation runs.

## Interface
- WIDTH, 64: operand and result width in bits (≥ 2).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (reset=0 clears the block).
- start  in  1  request; sampled at a rising edge only when busy=0.
- a  in  WIDTH  operand A; captured at the accepting edge.
- b  in  WIDTH  operand B; captured at the accepting edge.
- ALUControl  in  4  operation select; captured at the accepting edge.
- result  out  WIDTH  registered result; held until the next completion.
- zero  out  1  registered; 1 iff the completed result == 0; held with result.
- busy  out  1  1 while an iterative operation is in progress.
- done  out  1  one-cycle pulse; result and zero are valid in this cycle.

## Operation
- ALUControl encodings:
  - 0000: a & b
  - 0001: a | b
  - 0010: a + b (mod 2^WIDTH)
  - 0110: a − b (mod 2^WIDTH)
  - 0111: b
  - 1000: MUL, low WIDTH bits of a·b
  - 1001: UDIV, ⌊a/b⌋
  - 1010: UREM, a mod b
  - any other code: all ones.
- Simple ops (codes 0000–0111 and unlisted codes): computed at the accepting edge; the block never leaves IDLE.
- FSM states: IDLE and RUN.
  - IDLE → RUN: start=1 with code 1000, 1001 or 1010. Operands are loaded and the iteration counter is cleared.
  - RUN: one iteration per edge, WIDTH iterations in total. On the WIDTH-th iteration edge, result and zero are loaded, done is set and the FSM returns to IDLE.
- MUL: shift-add. The multiplicand shifts left and the multiplier shifts right. The accumulator is WIDTH bits wide; overflow bits are discarded.
- UDIV/UREM: restoring division, one quotient bit per iteration. The remainder register is WIDTH+1 bits wide for the trial subtraction.
- Divide by zero needs no special path and raises no flag. The restoring algorithm yields:
  - UDIV: all ones.
  - UREM: a.
- Operand changes after the accepting edge have no effect.
- start while busy=1 is ignored; it is not queued.
- In the cycle in which done=1, busy=0 and a new start is accepted (back-to-back operation).
- ALUControl is irrelevant when start=0.

## Timing
- Reset values, applied asynchronously while reset=0:
  - result = 0, zero = 0, busy = 0, done = 0
  - FSM = IDLE, counter = 0.
- Reset during RUN aborts the operation. No done pulse is produced and result stays 0 after release.
- Let t0 be the edge that accepts start. "After edge x" means the clock cycle that follows edge x.
- Simple op:
  - done=1 after t0, for exactly one cycle.
  - busy stays 0 throughout.
  - Latency: 1 cycle.
- Iterative op:
  - busy=1 after t0 through the cycle ending at edge t0+WIDTH.
  - At edge t0+WIDTH: busy→0, done→1, and result and zero update.
  - done=1 after t0+WIDTH.
  - Latency: WIDTH cycles. Throughput: one iterative op per WIDTH cycles.
- done deasserts after one cycle unless a new simple op is accepted in that same done cycle.
- result and zero change only on the edge that sets done.

## Test plan
- WIDTH=64, ADD a=5, b=7 → done one cycle later, result=12, zero=0, busy never 1. Then SUB a=7, b=7 on the next cycle → result=0, zero=1.
- MUL a=0xFFFF_FFFF, b=3 → busy high for 64 cycles, done at edge t0+64, result=0x2_FFFF_FFFD. MUL a=2^63, b=2 → result=0, zero=1.
- UDIV a=100, b=7 → result=14 after 64 cycles. UREM a=100, b=7 → result=2. UDIV a=100, b=0 → all ones. UREM a=100, b=0 → 100.
- During a MUL, pulse start with ADD, and change a and b at cycle 5 → the ADD is ignored and the MUL result uses the originally captured operands. In the done cycle, start with UDIV → it is accepted and busy=1 on the next cycle.
- Assert reset=0 asynchronously at cycle 10 of a UDIV → busy, done, result and zero read 0 immediately. After release, no done pulse occurs until a new start.
- Unlisted code 1111 → result=all ones, zero=0. Repeat with WIDTH=8: MUL 15·17 → 255 after 8 cycles; UDIV 200/9 → 22.
